// File: rtl/rv_wb_pkg.sv
// Shared types and helpers for the Wishbone master arbiter.
// Holds the FSM state encoding and the width helpers used by the top and the grant picker.
package rv_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam int unsigned BYTE_BITS = 8;

    function automatic int unsigned sel_width(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_arb_sel.sv
// Combinational grant picker: lowest-index request in fixed mode, or first
// request at/after the pointer (wrapping) in round-robin mode.
module rv_arb_sel
    import rv_wb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ROUND_ROBIN = 0,
    localparam int unsigned IDX_W      = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 gnt_valid_o,
    output logic [IDX_W-1:0]     gnt_idx_o
);

    always_comb begin
        int base;
        int p;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        p           = 0;
        base        = (ROUND_ROBIN != 0) ? int'(ptr_i) : 0;
        // Scan from the farthest offset down so the nearest request is assigned last and wins.
        for (int off = int'(NUM_PORTS) - 1; off >= 0; off--) begin
            p = base + off;
            if (p >= int'(NUM_PORTS)) begin
                p = p - int'(NUM_PORTS);
            end
            if (req_i[p]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Wishbone classic master arbiter: grants one requester at a time, drives registered
// CYC/STB only for real transfers, and ends each transfer on ack, error or ack timeout.
module rv_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ROUND_ROBIN  = 0,
    parameter int unsigned TIMEOUT_BITS = 8,
    localparam int unsigned SEL_WIDTH   = sel_width(DATA_WIDTH)
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_PORTS-1:0]            i_req,
    input  logic [NUM_PORTS-1:0]            i_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_wdata,
    input  logic [NUM_PORTS*SEL_WIDTH-1:0]  i_sel,
    output logic [NUM_PORTS-1:0]            o_ack,
    output logic [NUM_PORTS-1:0]            o_err,
    output logic [DATA_WIDTH-1:0]           o_rdata,
    output logic [ADDR_WIDTH-1:0]           o_wb_adr,
    output logic [DATA_WIDTH-1:0]           o_wb_dat,
    output logic                            o_wb_we,
    output logic [SEL_WIDTH-1:0]            o_wb_sel,
    output logic                            o_wb_stb,
    output logic                            o_wb_cyc,
    input  logic [DATA_WIDTH-1:0]           i_wb_dat,
    input  logic                            i_wb_ack,
    input  logic                            i_wb_err
);

    localparam int unsigned IDX_W = idx_width(NUM_PORTS);
    localparam int unsigned CNT_W = (TIMEOUT_BITS > 0) ? TIMEOUT_BITS : 1;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
    logic [SEL_WIDTH-1:0]  sel_arr   [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign addr_arr[gi]  = i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign sel_arr[gi]   = i_sel[gi*SEL_WIDTH +: SEL_WIDTH];
    end

    wb_state_e             state_q;
    logic [IDX_W-1:0]      gnt_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      ptr_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  we_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic                  cyc_q;
    logic [NUM_PORTS-1:0]  ack_q;
    logic [NUM_PORTS-1:0]  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  gnt_valid;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  tmo_hit;
    logic                  bus_done;

    rv_arb_sel #(
        .NUM_PORTS  (NUM_PORTS),
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_sel (
        .req_i      (i_req),
        .ptr_i      (ptr_q),
        .gnt_valid_o(gnt_valid),
        .gnt_idx_o  (gnt_idx)
    );

    assign ptr_d    = (gnt_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
    assign cnt_d    = cnt_q + 1'b1;
    assign tmo_hit  = (TIMEOUT_BITS != 0) && (&cnt_q);
    assign bus_done = i_wb_err | i_wb_ack | tmo_hit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            cyc_q   <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        gnt_q   <= gnt_idx;
                        adr_q   <= addr_arr[gnt_idx];
                        dat_q   <= wdata_arr[gnt_idx];
                        we_q    <= i_we[gnt_idx];
                        sel_q   <= sel_arr[gnt_idx];
                        cyc_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        // Error beats ack; a timeout only counts when the slave stayed silent.
                        if (i_wb_err || !i_wb_ack) begin
                            err_q[gnt_q] <= 1'b1;
                        end else begin
                            ack_q[gnt_q] <= 1'b1;
                            rdata_q      <= i_wb_dat;
                        end
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= '0;
                        state_q <= ST_RESP;
                        if (ROUND_ROBIN != 0) begin
                            ptr_q <= ptr_d;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ack    = ack_q;
    assign o_err    = err_q;
    assign o_rdata  = rdata_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_we  = we_q;
    assign o_wb_sel = sel_q;
    assign o_wb_stb = cyc_q;
    assign o_wb_cyc = cyc_q;

endmodule
